// File: rtl/hist_dispatch_pkg.sv
// =============================================================================
// hist_dispatch_pkg: shared types for the histogram bin dispatcher. Rev 1.0
// =============================================================================
`default_nettype none

package hist_dispatch_pkg;

    typedef enum logic [2:0] {
        EVT_ZERO       = 3'd0,
        EVT_POS        = 3'd1,
        EVT_NEG        = 3'd2,
        EVT_DROP_RANGE = 3'd3,
        EVT_DROP_PAIR  = 3'd4
    } evt_class_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fsm_t;

    localparam int SYNC_STAGES = 3;

    // Only events that land in a histogram bin are queued for the RAM.
    function automatic logic is_bin_event(input evt_class_t c);
        return (c == EVT_ZERO) || (c == EVT_POS) || (c == EVT_NEG);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hist_evt_fifo.sv
// =============================================================================
// hist_evt_fifo: synchronous FIFO of bin addresses; drops push when full. Rev 1.0
// =============================================================================
`default_nettype none

module hist_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (PTR_W + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hist_bin_dispatcher.sv
// =============================================================================
// hist_bin_dispatcher: maps start/stop events to signed-lag bins and issues
// req/ack increments. Define HIST_DISPATCH_STATS_EN for drop counters. Rev 1.0
// =============================================================================
`default_nettype none

module hist_bin_dispatcher
    import hist_dispatch_pkg::*;
#(
    parameter int CH_W       = 2,
    parameter int INT_W      = 7,
    parameter int ADDR_W     = 8,
    parameter int BASE       = 128,
    parameter int MAX_LAG    = 127,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_arrived,
    input  logic [CH_W-1:0]   start_ch,
    input  logic [CH_W-1:0]   end_ch,
    input  logic [INT_W-1:0]  interval,
    input  logic [CH_W-1:0]   cfg_ch_a,
    input  logic [CH_W-1:0]   cfg_ch_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_inc_req,
    input  logic              mem_inc_ack,
    output logic              fifo_full,
    output logic              evt_accepted,
    output logic [CNT_W-1:0]  drop_overflow_cnt,
    output logic [CNT_W-1:0]  drop_range_cnt,
    output logic [CNT_W-1:0]  drop_pair_cnt
);

    localparam int ARITH_W = ((ADDR_W + 1) > INT_W) ? (ADDR_W + 1) : (INT_W + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;

    if ((BASE < MAX_LAG) || ((BASE + MAX_LAG) >= (1 << ADDR_W))) begin : g_lag_window_check
        $error("hist_bin_dispatcher: lag window [BASE-MAX_LAG, BASE+MAX_LAG] does not fit ADDR_W");
    end
    if ((FIFO_DEPTH < 2) || ((1 << $clog2(FIFO_DEPTH)) != FIFO_DEPTH)) begin : g_depth_check
        $error("hist_bin_dispatcher: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rising;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], data_arrived};
        end
    end

    assign w_rising = (r_sync[2:1] == 2'b01);

    logic              r_cap_valid;
    logic [CH_W-1:0]   r_cap_start;
    logic [CH_W-1:0]   r_cap_end;
    logic [INT_W-1:0]  r_cap_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_valid <= 1'b0;
            r_cap_start <= '0;
            r_cap_end   <= '0;
            r_cap_int   <= '0;
        end else begin
            r_cap_valid <= w_rising;
            if (w_rising) begin
                r_cap_start <= start_ch;
                r_cap_end   <= end_ch;
                r_cap_int   <= interval;
            end
        end
    end

    logic               w_pair_ab;
    logic               w_pair_ba;
    logic [ARITH_W-1:0] w_int_ext;
    logic [ARITH_W-1:0] w_sum;
    evt_class_t         w_cls;

    // A==B makes every pair ambiguous, so it is treated as an invalid pair.
    assign w_pair_ab = (cfg_ch_a != cfg_ch_b) && (r_cap_start == cfg_ch_a) && (r_cap_end == cfg_ch_b);
    assign w_pair_ba = (cfg_ch_a != cfg_ch_b) && (r_cap_start == cfg_ch_b) && (r_cap_end == cfg_ch_a);
    assign w_int_ext = ARITH_W'(r_cap_int);

    always_comb begin
        w_cls = EVT_DROP_PAIR;
        w_sum = ARITH_W'(BASE);
        if (w_pair_ab || w_pair_ba) begin
            if (w_int_ext > ARITH_W'(MAX_LAG)) begin
                w_cls = EVT_DROP_RANGE;
            end else if (w_int_ext == '0) begin
                w_cls = EVT_ZERO;
            end else if (w_pair_ab) begin
                w_cls = EVT_POS;
                w_sum = ARITH_W'(BASE) + w_int_ext;
            end else begin
                w_cls = EVT_NEG;
                w_sum = ARITH_W'(BASE) - w_int_ext;
            end
        end
        // Any carry/borrow out of the address field means the bin is outside the window.
        if (((w_cls == EVT_POS) || (w_cls == EVT_NEG)) && (w_sum[ARITH_W-1:ADDR_W] != '0)) begin
            w_cls = EVT_DROP_RANGE;
        end
    end

    logic              r_cls_valid;
    evt_class_t        r_cls;
    logic [ADDR_W-1:0] r_cls_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cls_valid <= 1'b0;
            r_cls       <= EVT_DROP_PAIR;
            r_cls_addr  <= '0;
        end else begin
            r_cls_valid <= r_cap_valid;
            r_cls       <= w_cls;
            r_cls_addr  <= w_sum[ADDR_W-1:0];
        end
    end

    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_fifo_dout;
    logic [FCNT_W-1:0] w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              r_evt_acc;

    assign w_push = r_cls_valid && is_bin_event(r_cls);

    hist_evt_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_cls_addr),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign fifo_full = (w_fifo_count == FCNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_acc <= 1'b0;
        end else begin
            r_evt_acc <= w_push && !w_fifo_full;
        end
    end

    assign evt_accepted = r_evt_acc;

    fsm_t              r_state;
    fsm_t              w_next_state;
    logic [ADDR_W-1:0] r_mem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Leaving REQ always passes through IDLE, which guarantees a gap between requests.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (mem_inc_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr <= '0;
        end else if (w_pop) begin
            r_mem_addr <= w_fifo_dout;
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_inc_req = (r_state == REQ);

`ifdef HIST_DISPATCH_STATS_EN
    logic [CNT_W-1:0] r_drop_ovf;
    logic [CNT_W-1:0] r_drop_rng;
    logic [CNT_W-1:0] r_drop_pair;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_ovf  <= '0;
            r_drop_rng  <= '0;
            r_drop_pair <= '0;
        end else begin
            if (w_push && w_fifo_full && (r_drop_ovf != '1)) begin
                r_drop_ovf <= r_drop_ovf + CNT_W'(1);
            end
            if (r_cls_valid && (r_cls == EVT_DROP_RANGE) && (r_drop_rng != '1)) begin
                r_drop_rng <= r_drop_rng + CNT_W'(1);
            end
            if (r_cls_valid && (r_cls == EVT_DROP_PAIR) && (r_drop_pair != '1)) begin
                r_drop_pair <= r_drop_pair + CNT_W'(1);
            end
        end
    end

    assign drop_overflow_cnt = r_drop_ovf;
    assign drop_range_cnt    = r_drop_rng;
    assign drop_pair_cnt     = r_drop_pair;
`else
    assign drop_overflow_cnt = '0;
    assign drop_range_cnt    = '0;
    assign drop_pair_cnt     = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hist_bin_dispatcher.sv
// =============================================================================
// tb_hist_bin_dispatcher: scoreboard bench with a lag-arithmetic reference model.
// =============================================================================
`default_nettype none

module tb_hist_bin_dispatcher;

    localparam int CH_W       = 2;
    localparam int INT_W      = 8;
    localparam int ADDR_W     = 8;
    localparam int BASE       = 128;
    localparam int MAX_LAG    = 127;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 16;
`ifdef HIST_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              data_arrived;
    logic [CH_W-1:0]   start_ch;
    logic [CH_W-1:0]   end_ch;
    logic [INT_W-1:0]  interval;
    logic [CH_W-1:0]   cfg_ch_a;
    logic [CH_W-1:0]   cfg_ch_b;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_inc_req;
    logic              mem_inc_ack;
    logic              fifo_full;
    logic              evt_accepted;
    logic [CNT_W-1:0]  drop_overflow_cnt;
    logic [CNT_W-1:0]  drop_range_cnt;
    logic [CNT_W-1:0]  drop_pair_cnt;

    hist_bin_dispatcher #(
        .CH_W       (CH_W),
        .INT_W      (INT_W),
        .ADDR_W     (ADDR_W),
        .BASE       (BASE),
        .MAX_LAG    (MAX_LAG),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .data_arrived      (data_arrived),
        .start_ch          (start_ch),
        .end_ch            (end_ch),
        .interval          (interval),
        .cfg_ch_a          (cfg_ch_a),
        .cfg_ch_b          (cfg_ch_b),
        .mem_addr          (mem_addr),
        .mem_inc_req       (mem_inc_req),
        .mem_inc_ack       (mem_inc_ack),
        .fifo_full         (fifo_full),
        .evt_accepted      (evt_accepted),
        .drop_overflow_cnt (drop_overflow_cnt),
        .drop_range_cnt    (drop_range_cnt),
        .drop_pair_cnt     (drop_pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] exp_q[$];
    int exp_acc  = 0;
    int seen_acc = 0;
    int exp_rng  = 0;
    int exp_pair = 0;
    int exp_ovf  = 0;

    bit ack_hold  = 1'b0;
    bit ack_noise = 1'b0;
    int ack_dmin  = 0;
    int ack_dmax  = 0;
    int exp_len   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: lag = +interval for A->B, -interval for B->A; bin = BASE + lag.
    function automatic void model_evt(input int s, input int e, input int iv, input bit ovf);
        int a = int'(cfg_ch_a);
        int b = int'(cfg_ch_b);
        bit ab = (a != b) && (s == a) && (e == b);
        bit ba = (a != b) && (s == b) && (e == a);
        int lag;
        if (!(ab || ba)) begin
            exp_pair++;
        end else if (iv > MAX_LAG) begin
            exp_rng++;
        end else if (ovf) begin
            exp_ovf++;
        end else begin
            lag = ab ? iv : -iv;
            exp_q.push_back(ADDR_W'(BASE + lag));
            exp_acc++;
        end
    endfunction

    task automatic send_evt(input int s, input int e, input int iv, input int gap, input bit ovf);
        @(negedge clk);
        start_ch     = CH_W'(s);
        end_ch       = CH_W'(e);
        interval     = INT_W'(iv);
        data_arrived = 1'b1;
        model_evt(s, e, iv, ovf);
        @(negedge clk);
        data_arrived = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        bit done = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mem_inc_req) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drained"}, {31'd0, done}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_counters(input string name);
        check({name, "_drop_range"},    32'(drop_range_cnt),    STATS ? 32'(exp_rng)  : 32'd0);
        check({name, "_drop_pair"},     32'(drop_pair_cnt),     STATS ? 32'(exp_pair) : 32'd0);
        check({name, "_drop_overflow"}, 32'(drop_overflow_cnt), STATS ? 32'(exp_ovf)  : 32'd0);
    endtask

    // RAM-side responder: acks after a random delay; may toggle ack while idle.
    initial begin
        int seen = 0;
        int d    = 0;
        mem_inc_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mem_inc_req) begin
                seen        = 0;
                mem_inc_ack = ack_noise ? 1'($urandom_range(1, 0)) : 1'b0;
            end else begin
                if (seen == 0) d = $urandom_range(ack_dmax, ack_dmin);
                seen++;
                if (!ack_hold && seen > d) begin
                    mem_inc_ack = 1'b1;
                    exp_len     = seen;
                end else begin
                    mem_inc_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on each new request and checks the handshake.
    initial begin
        bit                prev = 1'b0;
        logic [ADDR_W-1:0] cur  = '0;
        int                len  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
                len  = 0;
            end else begin
                if (evt_accepted) seen_acc++;
                if (mem_inc_req) begin
                    if (!prev) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_req: got addr %0d, expected no request (t=%0t)", mem_addr, $time);
                            cur = mem_addr;
                        end else begin
                            cur = exp_q.pop_front();
                            check("req_addr", 32'(mem_addr), 32'(cur));
                        end
                        len = 1;
                    end else begin
                        len++;
                        check("addr_stable", 32'(mem_addr), 32'(cur));
                    end
                end else if (prev) begin
                    check("req_len", len, exp_len);
                end
                prev = mem_inc_req;
            end
        end
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        rst          = 1'b1;
        data_arrived = 1'b0;
        start_ch     = '0;
        end_ch       = '0;
        interval     = '0;
        cfg_ch_a     = 2'd0;
        cfg_ch_b     = 2'd3;
        repeat (3) @(negedge clk);
        check("rst_req",       32'(mem_inc_req),  32'd0);
        check("rst_full",      32'(fifo_full),    32'd0);
        check("rst_evt_acc",   32'(evt_accepted), 32'd0);
        check("rst_addr",      32'(mem_addr),     32'd0);
        check_counters("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero lag with immediate ack; also pins the pipeline latency.
        @(negedge clk);
        start_ch = 2'd0; end_ch = 2'd3; interval = '0; data_arrived = 1'b1;
        model_evt(0, 3, 0, 1'b0);
        @(posedge clk);
        #1 data_arrived = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("lat_req_k4", 32'(mem_inc_req),  32'd0);
        check("lat_acc_k4", 32'(evt_accepted), 32'd1);
        @(posedge clk);
        #1;
        check("lat_req_k5", 32'(mem_inc_req), 32'd1);
        check("lat_addr",   32'(mem_addr),    32'd128);
        drain("zero", 50);

        // Positive/negative lags, boundaries, 4-cycle ack delay.
        cfg_ch_a = 2'd1; cfg_ch_b = 2'd2;
        ack_dmin = 4; ack_dmax = 4;
        send_evt(1, 2, 5,   8, 1'b0);
        send_evt(2, 1, 5,   8, 1'b0);
        send_evt(1, 2, 127, 8, 1'b0);
        send_evt(2, 1, 127, 8, 1'b0);
        send_evt(1, 2, 128, 8, 1'b0);
        send_evt(2, 1, 200, 8, 1'b0);
        drain("lags", 100);
        check_counters("lags");

        // Invalid pairs.
        cfg_ch_a = 2'd0; cfg_ch_b = 2'd3;
        ack_dmin = 0; ack_dmax = 1;
        send_evt(2, 2, 5, 4, 1'b0);
        send_evt(0, 1, 3, 4, 1'b0);
        send_evt(3, 3, 0, 4, 1'b0);
        cfg_ch_a = 2'd1; cfg_ch_b = 2'd1;
        send_evt(1, 1, 4, 4, 1'b0);
        drain("pairs", 50);
        check_counters("pairs");
        check("pairs_acc", seen_acc, exp_acc);

        // Overflow: ack withheld, six events four clocks apart.
        cfg_ch_a = 2'd0; cfg_ch_b = 2'd3;
        ack_hold = 1'b1;
        for (int i = 0; i < 6; i++) send_evt(0, 3, i + 1, 3, i == 5);
        repeat (6) @(negedge clk);
        check("ovf_full", 32'(fifo_full),   32'd1);
        check("ovf_req",  32'(mem_inc_req), 32'd1);
        check("ovf_acc",  seen_acc, exp_acc);
        ack_hold = 1'b0;
        ack_dmin = 0; ack_dmax = 2;
        drain("ovf", 100);
        check("ovf_full_after", 32'(fifo_full), 32'd0);
        check_counters("ovf");

        // Randomised traffic with ack noise while idle.
        ack_noise = 1'b1;
        for (int n = 0; n < 60; n++) begin
            int s, e, iv, r;
            if (n % 15 == 0) begin
                cfg_ch_a = CH_W'($urandom_range(3, 0));
                cfg_ch_b = ($urandom_range(9, 0) == 0) ? cfg_ch_a : CH_W'($urandom_range(3, 0));
            end
            r = $urandom_range(9, 0);
            if (r < 4)      begin s = int'(cfg_ch_a); e = int'(cfg_ch_b); end
            else if (r < 7) begin s = int'(cfg_ch_b); e = int'(cfg_ch_a); end
            else            begin s = $urandom_range(3, 0); e = $urandom_range(3, 0); end
            r = $urandom_range(9, 0);
            case (r)
                0:       iv = 0;
                1:       iv = 127;
                2:       iv = 128;
                3:       iv = 255;
                default: iv = $urandom_range(255, 0);
            endcase
            send_evt(s, e, iv, $urandom_range(6, 3), 1'b0);
        end
        ack_noise = 1'b0;
        drain("rand", 200);
        check_counters("rand");
        check("rand_acc", seen_acc, exp_acc);

        // Reset while a request is pending with entries queued.
        cfg_ch_a = 2'd0; cfg_ch_b = 2'd3;
        ack_hold = 1'b1;
        for (int i = 0; i < 3; i++) send_evt(3, 0, 10 + i, 3, 1'b0);
        repeat (6) @(negedge clk);
        check("mid_req", 32'(mem_inc_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_rng = 0; exp_pair = 0; exp_ovf = 0;
        check("mid_rst_req",  32'(mem_inc_req), 32'd0);
        check("mid_rst_full", 32'(fifo_full),   32'd0);
        check_counters("mid_rst");
        rst = 1'b0;
        ack_hold = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_req", 32'(mem_inc_req), 32'd0);
        check("final_acc", seen_acc, exp_acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
